// File: rtl/rename_allocator.sv
// rename_allocator: destination-side rename stage.
// Owns the register alias table (arch 2..11) and the physical-register free
// list. It allocates up to two destinations per microop, tracks per-mapping
// done bits from writeback, and accepts retired registers back into the list.

`ifndef PHYS_REGS
`define PHYS_REGS 32
`endif

module rename_allocator #(
  localparam int P = $clog2(`PHYS_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_valid,
  output logic              alloc_ready,
  input  logic [7:0]        dst_arch,
  input  logic [1:0]        dst_valid,
  output logic [2*P-1:0]    dst_phys,
  output logic [2*P-1:0]    old_phys,
  input  logic              wb_valid,
  input  logic [P-1:0]      wb_phys,
  input  logic [1:0]        free_valid,
  input  logic [2*P-1:0]    free_phys,
  output logic [9:0]        rat_done,
  output logic [10*P-1:0]   rat_aliases,
  output logic [P:0]        free_count
);

  localparam int NR = `PHYS_REGS;
  localparam int NA = 10;
  localparam logic [P:0] FL_DEPTH = (P+1)'(NR);
  localparam logic [P:0] FL_INIT  = (P+1)'(NR - 12);

  logic [P-1:0] rat [NA];
  logic [NA-1:0] done_q;
  logic [P-1:0] fl [NR];
  logic [P-1:0] head;
  logic [P-1:0] tail;
  logic [P:0]   count;

  logic [3:0]   a0, a1, i0, i1;
  logic         e0, e1;
  logic [1:0]   need;
  logic         fire;
  logic [P-1:0] p0, p1, o0, o1;
  logic [P-1:0] f0, f1;
  logic         want0, want1, ok0, ok1, ovf;
  logic [P:0]   n_alloc, cnt_a, cnt_b, count_next;
  logic [P-1:0] tail1;

  // Decode destinations, form the allocation handshake and the free-list pushes
  always_comb begin
    a0 = dst_arch[3:0];
    a1 = dst_arch[7:4];
    i0 = a0 - 4'd2;
    i1 = a1 - 4'd2;
    e0 = dst_valid[0] && (a0 >= 4'd2) && (a0 <= 4'd11);
    e1 = dst_valid[1] && (a1 >= 4'd2) && (a1 <= 4'd11);
    need = {1'b0, e0} + {1'b0, e1};
    alloc_ready = (count >= {{(P-1){1'b0}}, need});
    fire = alloc_valid && alloc_ready;

    // dest1 takes the second head slot only when dest0 consumes the first
    p0 = e0 ? fl[head] : '0;
    p1 = '0;
    if (e1) p1 = e0 ? fl[head + P'(1)] : fl[head];

    // A repeated destination sees dest0's fresh register as its prior mapping
    o0 = e0 ? rat[i0] : '0;
    o1 = '0;
    if (e1) o1 = (e0 && (a0 == a1)) ? p0 : rat[i1];

    dst_phys = {p1, p0};
    old_phys = {o1, o0};

    n_alloc = fire ? {{(P-1){1'b0}}, need} : '0;
    f0 = free_phys[P-1:0];
    f1 = free_phys[2*P-1:P];
    want0 = free_valid[0] && (f0 > P'(1));
    want1 = free_valid[1] && (f1 > P'(1));
    cnt_a = count - n_alloc;
    ok0 = want0 && (cnt_a < FL_DEPTH);
    cnt_b = cnt_a + {{P{1'b0}}, ok0};
    ok1 = want1 && (cnt_b < FL_DEPTH);
    ovf = (want0 && !ok0) || (want1 && !ok1);
    count_next = cnt_b + {{P{1'b0}}, ok1};
    tail1 = tail + P'(ok0);
  end

  // RAT, done bits and free list update; allocation overrides writeback
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NA; i++) begin
        rat[4'(i)]    <= P'(i + 2);
        done_q[4'(i)] <= 1'b1;
      end
      for (int i = 0; i < NR - 12; i++) begin
        fl[P'(i)] <= P'(i + 12);
      end
      head  <= '0;
      tail  <= P'(NR - 12);
      count <= FL_INIT;
    end else begin
      for (int i = 0; i < NA; i++) begin
        if (wb_valid && (wb_phys > P'(1)) && (rat[4'(i)] == wb_phys))
          done_q[4'(i)] <= 1'b1;
      end
      if (fire && e0) begin
        rat[i0]    <= p0;
        done_q[i0] <= 1'b0;
      end
      if (fire && e1) begin
        rat[i1]    <= p1;
        done_q[i1] <= 1'b0;
      end
      if (fire) head <= head + P'(need);
      if (ok0) fl[tail]  <= f0;
      if (ok1) fl[tail1] <= f1;
      tail  <= tail1 + P'(ok1);
      count <= count_next;
    end
  end

  // Registered state drives the decoder-facing outputs directly
  always_comb begin
    for (int i = 0; i < NA; i++) begin
      rat_aliases[i*P +: P] = rat[4'(i)];
    end
    rat_done   = done_q;
    free_count = count;
  end

  // A release into a full free list is a bookkeeping bug upstream; it is dropped
  free_list_no_overflow: assert property (@(posedge clk) disable iff (rst) !ovf);

endmodule

// File: tb/tb_rename_allocator.sv
// Directed bench for rename_allocator: the driver queues expected responses,
// a negedge monitor compares them against the DUT outputs.

module tb_rename_allocator;

  localparam int P = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          alloc_valid = 1'b0;
  logic          alloc_ready;
  logic [7:0]    dst_arch = '0;
  logic [1:0]    dst_valid = '0;
  logic [2*P-1:0] dst_phys;
  logic [2*P-1:0] old_phys;
  logic          wb_valid = 1'b0;
  logic [P-1:0]  wb_phys = '0;
  logic [1:0]    free_valid = '0;
  logic [2*P-1:0] free_phys = '0;
  logic [9:0]    rat_done;
  logic [10*P-1:0] rat_aliases;
  logic [P:0]    free_count;

  rename_allocator dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .dst_arch(dst_arch), .dst_valid(dst_valid),
    .dst_phys(dst_phys), .old_phys(old_phys),
    .wb_valid(wb_valid), .wb_phys(wb_phys),
    .free_valid(free_valid), .free_phys(free_phys),
    .rat_done(rat_done), .rat_aliases(rat_aliases),
    .free_count(free_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic        ready;
    logic [P:0]  count;
    logic [9:0]  done;
    logic [10*P-1:0] aliases;
  } st_t;

  typedef struct {
    logic [2*P-1:0] dp;
    logic [2*P-1:0] op;
  } al_t;

  st_t st_q[$];
  al_t al_q[$];

  int checks = 0;
  int errors = 0;
  logic stim_done = 1'b0;
  logic final_done = 1'b0;

  logic [P-1:0] m_alias [10];
  logic [9:0]   m_done;

  task automatic reset_model();
    for (int i = 0; i < 10; i++) m_alias[i] = 5'(i + 2);
    m_done = 10'h3FF;
  endtask

  function automatic logic [10*P-1:0] pack_alias();
    logic [10*P-1:0] v;
    for (int i = 0; i < 10; i++) v[i*P +: P] = m_alias[i];
    return v;
  endfunction

  task automatic step(input logic r, input logic av, input logic [7:0] da,
                      input logic [1:0] dv, input logic wv, input logic [P-1:0] wp,
                      input logic [1:0] fv, input logic [2*P-1:0] fp);
    @(posedge clk);
    #1;
    rst = r; alloc_valid = av; dst_arch = da; dst_valid = dv;
    wb_valid = wv; wb_phys = wp; free_valid = fv; free_phys = fp;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 5'd0, 2'b00, 10'd0);
  endtask

  task automatic exp_state(input logic rdy, input logic [P:0] c);
    st_t s;
    s.cyc = cyc; s.ready = rdy; s.count = c; s.done = m_done; s.aliases = pack_alias();
    st_q.push_back(s);
  endtask

  task automatic exp_alloc(input logic [P-1:0] d1, input logic [P-1:0] d0,
                           input logic [P-1:0] o1, input logic [P-1:0] o0);
    al_t a;
    a.dp = {d1, d0}; a.op = {o1, o0};
    al_q.push_back(a);
  endtask

  // Monitor: compare queued expectations against the DUT away from the clock edge
  always @(negedge clk) begin
    if (st_q.size() > 0 && st_q[0].cyc == cyc) begin
      st_t s;
      s = st_q.pop_front();
      checks += 4;
      if (alloc_ready !== s.ready) begin
        errors++;
        $display("FAIL alloc_ready cyc=%0d got=%0d exp=%0d", cyc, alloc_ready, s.ready);
      end
      if (free_count !== s.count) begin
        errors++;
        $display("FAIL free_count cyc=%0d got=%0d exp=%0d", cyc, free_count, s.count);
      end
      if (rat_done !== s.done) begin
        errors++;
        $display("FAIL rat_done cyc=%0d got=%h exp=%h", cyc, rat_done, s.done);
      end
      if (rat_aliases !== s.aliases) begin
        errors++;
        $display("FAIL rat_aliases cyc=%0d got=%h exp=%h", cyc, rat_aliases, s.aliases);
      end
    end
    if (!rst && alloc_valid && alloc_ready) begin
      if (al_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_alloc cyc=%0d dst_phys=%h old_phys=%h", cyc, dst_phys, old_phys);
      end else begin
        al_t a;
        a = al_q.pop_front();
        checks += 2;
        if (dst_phys !== a.dp) begin
          errors++;
          $display("FAIL dst_phys cyc=%0d got=%h exp=%h", cyc, dst_phys, a.dp);
        end
        if (old_phys !== a.op) begin
          errors++;
          $display("FAIL old_phys cyc=%0d got=%h exp=%h", cyc, old_phys, a.op);
        end
      end
    end
    if (stim_done && !final_done) begin
      checks += 2;
      if (al_q.size() != 0) begin
        errors++;
        $display("FAIL alloc_not_seen got=%0d pending exp=0", al_q.size());
      end
      if (st_q.size() != 0) begin
        errors++;
        $display("FAIL state_not_checked got=%0d pending exp=0", st_q.size());
      end
      final_done <= 1'b1;
    end
  end

  // Stimulus
  initial begin
    step(1'b1, 1'b0, 8'h00, 2'b00, 1'b0, 5'd0, 2'b00, 10'd0);
    step(1'b1, 1'b0, 8'h00, 2'b00, 1'b0, 5'd0, 2'b00, 10'd0);
    reset_model();
    idle(); exp_state(1'b1, 6'd20);

    // Two destinations from a fresh free list
    step(1'b0, 1'b1, 8'h32, 2'b11, 1'b0, 5'd0, 2'b00, 10'd0);
    exp_state(1'b1, 6'd20); exp_alloc(5'd13, 5'd12, 5'd3, 5'd2);
    m_alias[0] = 5'd12; m_alias[1] = 5'd13; m_done[1:0] = 2'b00;

    // Writeback of 12 sets arch 2 only; writeback of 7 touches nothing pending
    step(1'b0, 1'b0, 8'h00, 2'b00, 1'b1, 5'd12, 2'b00, 10'd0);
    exp_state(1'b1, 6'd18);
    m_done[0] = 1'b1;
    step(1'b0, 1'b0, 8'h00, 2'b00, 1'b1, 5'd7, 2'b00, 10'd0);
    exp_state(1'b1, 6'd18);
    idle(); exp_state(1'b1, 6'd18);

    // Same arch in both slots
    step(1'b1, 1'b0, 8'h00, 2'b00, 1'b0, 5'd0, 2'b00, 10'd0);
    reset_model();
    idle(); exp_state(1'b1, 6'd20);
    step(1'b0, 1'b1, 8'h55, 2'b11, 1'b0, 5'd0, 2'b00, 10'd0);
    exp_state(1'b1, 6'd20); exp_alloc(5'd13, 5'd12, 5'd12, 5'd5);
    m_alias[3] = 5'd13; m_done[3] = 1'b0;
    idle(); exp_state(1'b1, 6'd18);

    // Drain the free list
    step(1'b1, 1'b0, 8'h00, 2'b00, 1'b0, 5'd0, 2'b00, 10'd0);
    reset_model();
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b1, 8'h32, 2'b11, 1'b0, 5'd0, 2'b00, 10'd0);
      exp_state(1'b1, 6'(20 - 2*k));
      if (k == 0) exp_alloc(5'd13, 5'd12, 5'd3, 5'd2);
      else exp_alloc(5'(13 + 2*k), 5'(12 + 2*k), 5'(11 + 2*k), 5'(10 + 2*k));
      m_alias[0] = 5'(12 + 2*k); m_alias[1] = 5'(13 + 2*k); m_done[1:0] = 2'b00;
    end
    step(1'b0, 1'b1, 8'h32, 2'b01, 1'b0, 5'd0, 2'b00, 10'd0);
    exp_state(1'b0, 6'd0);
    step(1'b0, 1'b1, 8'h32, 2'b00, 1'b0, 5'd0, 2'b00, 10'd0);
    exp_state(1'b1, 6'd0); exp_alloc(5'd0, 5'd0, 5'd0, 5'd0);

    // Free while empty: not allocatable until the next cycle
    step(1'b0, 1'b1, 8'h32, 2'b11, 1'b0, 5'd0, 2'b11, {5'd3, 5'd2});
    exp_state(1'b0, 6'd0);
    step(1'b0, 1'b1, 8'h32, 2'b11, 1'b0, 5'd0, 2'b00, 10'd0);
    exp_state(1'b1, 6'd2); exp_alloc(5'd3, 5'd2, 5'd31, 5'd30);
    m_alias[0] = 5'd2; m_alias[1] = 5'd3;
    idle(); exp_state(1'b1, 6'd0);

    // Non-renamable destinations
    step(1'b0, 1'b1, 8'hC0, 2'b11, 1'b0, 5'd0, 2'b00, 10'd0);
    exp_state(1'b1, 6'd0); exp_alloc(5'd0, 5'd0, 5'd0, 5'd0);
    idle(); exp_state(1'b1, 6'd0);

    // Alloc, writeback of the displaced alias and a free in one cycle
    step(1'b1, 1'b0, 8'h00, 2'b00, 1'b0, 5'd0, 2'b00, 10'd0);
    reset_model();
    step(1'b0, 1'b1, 8'h32, 2'b11, 1'b1, 5'd2, 2'b01, {5'd0, 5'd9});
    exp_state(1'b1, 6'd20); exp_alloc(5'd13, 5'd12, 5'd3, 5'd2);
    m_alias[0] = 5'd12; m_alias[1] = 5'd13; m_done[1:0] = 2'b00;
    idle(); exp_state(1'b1, 6'd19);

    // Reset in the middle of traffic
    step(1'b1, 1'b1, 8'h32, 2'b11, 1'b1, 5'd12, 2'b11, {5'd5, 5'd4});
    exp_state(1'b1, 6'd19);
    reset_model();
    idle(); exp_state(1'b1, 6'd20);

    idle();
    idle();
    stim_done = 1'b1;
    for (int i = 0; i < 10 && !final_done; i++) @(posedge clk);
    if (!final_done) begin
      checks++; errors++;
      $display("FAIL monitor_final got=0 exp=1");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
